// File: rtl/chimera_wide_bypass_switch.sv
// Wide-path bypass-mode switch: flips the adapter's bypass mode only once all wide AXI traffic has drained.
// Zero-latency pass-through; AW/AR are stalled while a switch is pending or the outstanding limit is reached.
package chimera_wide_axi_pkg;
    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 48;
    localparam int unsigned DataW = 512;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } ax_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } w_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

module chimera_wide_bypass_switch #(
    parameter int unsigned MaxTxn        = 8,
    parameter logic        BypassDefault = 1'b0,
    parameter type         axi_req_t     = chimera_wide_axi_pkg::req_t,
    parameter type         axi_resp_t    = chimera_wide_axi_pkg::resp_t
) (
    input  logic                        soc_clk_i,
    input  logic                        rst_i,
    input  logic                        bypass_req_i,
    input  axi_req_t                    slv_req_i,
    output axi_resp_t                   slv_resp_o,
    output axi_req_t                    mst_req_o,
    input  axi_resp_t                   mst_resp_i,
    output logic                        bypass_o,
    output logic                        busy_o,
    output logic [$clog2(MaxTxn+1)-1:0] wr_cnt_o,
    output logic [$clog2(MaxTxn+1)-1:0] rd_cnt_o
);
    localparam int unsigned CntW = $clog2(MaxTxn + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxn);

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_e;

    state_e          state;
    logic [CntW-1:0] wr_cnt, rd_cnt;
    logic            aw_hold, ar_hold;
    logic            gate_aw, gate_ar;
    logic            aw_hs, ar_hs, b_hs, r_last_hs;
    logic            drained;

    // A request already presented downstream is never withdrawn, even if a switch starts.
    assign gate_aw = !aw_hold && ((state != IDLE) || (wr_cnt == MaxCnt));
    assign gate_ar = !ar_hold && ((state != IDLE) || (rd_cnt == MaxCnt));

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && !gate_aw;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && !gate_ar;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !gate_aw;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !gate_ar;
    end

    assign aw_hs     = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            aw_hold <= 1'b0;
            ar_hold <= 1'b0;
        end else begin
            aw_hold <= mst_req_o.aw_valid && !mst_resp_i.aw_ready;
            ar_hold <= mst_req_o.ar_valid && !mst_resp_i.ar_ready;
            if (aw_hs && !b_hs) begin
                wr_cnt <= wr_cnt + 1'b1;
            end else if (b_hs && !aw_hs && (wr_cnt != '0)) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
            if (ar_hs && !r_last_hs) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else if (r_last_hs && !ar_hs && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
        end
    end

    assign drained = (wr_cnt == '0) && (rd_cnt == '0) && !aw_hold && !ar_hold;

    always_ff @(posedge soc_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            bypass_o <= BypassDefault;
            busy_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bypass_req_i != bypass_o) begin
                        state  <= DRAIN;
                        busy_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    // The request is re-sampled here, so a reverted request ends as a no-op switch.
                    if (drained) begin
                        state    <= SWITCH;
                        bypass_o <= bypass_req_i;
                    end
                end
                SWITCH: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign wr_cnt_o = wr_cnt;
    assign rd_cnt_o = rd_cnt;

    // A response with nothing outstanding means the downstream side broke protocol.
    a_no_b_underflow: assert property (@(posedge soc_clk_i) disable iff (rst_i)
        !(b_hs && !aw_hs && (wr_cnt == '0)));
    a_no_r_underflow: assert property (@(posedge soc_clk_i) disable iff (rst_i)
        !(r_last_hs && !ar_hs && (rd_cnt == '0)));

endmodule

// File: tb/tb_chimera_wide_bypass_switch.sv
// Directed bench for chimera_wide_bypass_switch: mode-switch timing, drain, saturation, valid stability, reset.
module tb_chimera_wide_bypass_switch;
    import chimera_wide_axi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bypass_req;
    req_t       slv_req, mst_req;
    resp_t      slv_resp, mst_resp;
    logic       bypass, busy;
    logic [3:0] wr_cnt, rd_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    chimera_wide_bypass_switch #(
        .MaxTxn       (8),
        .BypassDefault(1'b0)
    ) dut (
        .soc_clk_i   (clk),
        .rst_i       (rst),
        .bypass_req_i(bypass_req),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .bypass_o    (bypass),
        .busy_o      (busy),
        .wr_cnt_o    (wr_cnt),
        .rd_cnt_o    (rd_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bypass_req = 1'b0;
        slv_req = '0;
        mst_resp = '0;
        #12;
        n_cmp++; if (bypass !== 1'b0) begin n_bad++; $display("FAIL rst_bypass: got %b want 0", bypass); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (wr_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_wr_cnt: got %0d want 0", wr_cnt); end
        n_cmp++; if (rd_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_rd_cnt: got %0d want 0", rd_cnt); end
        tick();
        rst = 1'b0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr = 48'h1234_5678_9abc;
        #1;
        n_cmp++; if (mst_req.aw_valid !== 1'b1 || mst_req.aw.addr !== 48'h1234_5678_9abc) begin
            n_bad++; $display("FAIL idle_aw_pass: got valid %b addr %h want 1 123456789abc", mst_req.aw_valid, mst_req.aw.addr);
        end
        slv_req.aw_valid = 1'b0;
    endtask

    task automatic test_idle_toggle();
        tick();
        bypass_req = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL toggle_c0_busy: got %b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b1 || bypass !== 1'b0) begin n_bad++; $display("FAIL toggle_c1: got busy %b bypass %b want 1 0", busy, bypass); end
        slv_req.ar_valid = 1'b1;
        mst_resp.ar_ready = 1'b1;
        #1;
        n_cmp++; if (slv_resp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
            n_bad++; $display("FAIL toggle_ar_gated: got ready %b valid %b want 0 0", slv_resp.ar_ready, mst_req.ar_valid);
        end
        tick();
        n_cmp++; if (busy !== 1'b1 || bypass !== 1'b1) begin n_bad++; $display("FAIL toggle_c2: got busy %b bypass %b want 1 1", busy, bypass); end
        tick();
        n_cmp++; if (busy !== 1'b0 || slv_resp.ar_ready !== 1'b1) begin
            n_bad++; $display("FAIL toggle_c3: got busy %b ar_ready %b want 0 1", busy, slv_resp.ar_ready);
        end
        tick();
        n_cmp++; if (rd_cnt !== 4'd1) begin n_bad++; $display("FAIL toggle_ar_count: got %0d want 1", rd_cnt); end
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last = 1'b1;
        slv_req.r_ready = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd0) begin n_bad++; $display("FAIL toggle_r_drain: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_drain_writes();
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready = 1'b1;
        slv_req.b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_req.aw_valid = 1'b1;
            slv_req.aw.id = 4'(i);
            tick();
        end
        slv_req.aw_valid = 1'b0;
        n_cmp++; if (wr_cnt !== 4'd3) begin n_bad++; $display("FAIL drain_wr_cnt3: got %0d want 3", wr_cnt); end
        bypass_req = 1'b0;
        tick();
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id = 4'd7;
        #1;
        n_cmp++; if (slv_resp.aw_ready !== 1'b0 || mst_req.aw_valid !== 1'b0) begin
            n_bad++; $display("FAIL drain_aw_stall: got ready %b valid %b want 0 0", slv_resp.aw_ready, mst_req.aw_valid);
        end
        for (int i = 0; i < 12; i++) begin
            slv_req.w_valid = 1'b1;
            slv_req.w.last = ((i % 4) == 3);
            slv_req.w.strb = '1;
            #1;
            if (i == 0) begin
                n_cmp++; if (mst_req.w_valid !== 1'b1 || slv_resp.w_ready !== 1'b1) begin
                    n_bad++; $display("FAIL drain_w_pass: got valid %b ready %b want 1 1", mst_req.w_valid, slv_resp.w_ready);
                end
            end
            tick();
        end
        slv_req.w_valid = 1'b0;
        repeat (8) tick();
        n_cmp++; if (wr_cnt !== 4'd3 || bypass !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL drain_waiting: got cnt %0d bypass %b busy %b want 3 1 1", wr_cnt, bypass, busy);
        end
        for (int i = 0; i < 3; i++) begin
            mst_resp.b_valid = 1'b1;
            mst_resp.b.id = 4'(i);
            tick();
        end
        mst_resp.b_valid = 1'b0;
        n_cmp++; if (wr_cnt !== 4'd0 || bypass !== 1'b1) begin
            n_bad++; $display("FAIL drain_after_b: got cnt %0d bypass %b want 0 1", wr_cnt, bypass);
        end
        tick();
        n_cmp++; if (bypass !== 1'b0 || slv_resp.aw_ready !== 1'b0) begin
            n_bad++; $display("FAIL drain_switch: got bypass %b aw_ready %b want 0 0", bypass, slv_resp.aw_ready);
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || slv_resp.aw_ready !== 1'b1) begin
            n_bad++; $display("FAIL drain_release: got busy %b aw_ready %b want 0 1", busy, slv_resp.aw_ready);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        n_cmp++; if (wr_cnt !== 4'd1) begin n_bad++; $display("FAIL drain_stalled_aw_taken: got %0d want 1", wr_cnt); end
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
    endtask

    task automatic test_saturation();
        mst_resp.ar_ready = 1'b1;
        slv_req.r_ready = 1'b1;
        slv_req.ar_valid = 1'b1;
        repeat (8) tick();
        n_cmp++; if (rd_cnt !== 4'd8) begin n_bad++; $display("FAIL sat_cnt8: got %0d want 8", rd_cnt); end
        n_cmp++; if (slv_resp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
            n_bad++; $display("FAIL sat_ar9_stall: got ready %b valid %b want 0 0", slv_resp.ar_ready, mst_req.ar_valid);
        end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last = 1'b0;
        tick();
        n_cmp++; if (rd_cnt !== 4'd8) begin n_bad++; $display("FAIL sat_nonlast_r: got %0d want 8", rd_cnt); end
        mst_resp.r.last = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd7 || slv_resp.ar_ready !== 1'b1) begin
            n_bad++; $display("FAIL sat_after_rlast: got cnt %0d ready %b want 7 1", rd_cnt, slv_resp.ar_ready);
        end
        tick();
        slv_req.ar_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd8) begin n_bad++; $display("FAIL sat_ar9_taken: got %0d want 8", rd_cnt); end
        mst_resp.r_valid = 1'b1;
        repeat (8) tick();
        mst_resp.r_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_drain: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_valid_stability();
        mst_resp.aw_ready = 1'b0;
        slv_req.aw_valid = 1'b1;
        bypass_req = 1'b1;
        #1;
        n_cmp++; if (mst_req.aw_valid !== 1'b1) begin n_bad++; $display("FAIL stab_c0_valid: got %b want 1", mst_req.aw_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (mst_req.aw_valid !== 1'b1 || busy !== 1'b1) begin
                n_bad++; $display("FAIL stab_hold_%0d: got valid %b busy %b want 1 1", i, mst_req.aw_valid, busy);
            end
        end
        mst_resp.aw_ready = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        n_cmp++; if (wr_cnt !== 4'd1) begin n_bad++; $display("FAIL stab_count: got %0d want 1", wr_cnt); end
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b1 || bypass !== 1'b0) begin
            n_bad++; $display("FAIL stab_wait_b: got busy %b bypass %b want 1 0", busy, bypass);
        end
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        tick();
        n_cmp++; if (bypass !== 1'b1) begin n_bad++; $display("FAIL stab_switch: got %b want 1", bypass); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stab_idle: got %b want 0", busy); end
    endtask

    task automatic test_simul_incdec();
        slv_req.ar_valid = 1'b1;
        repeat (2) tick();
        n_cmp++; if (rd_cnt !== 4'd2) begin n_bad++; $display("FAIL simul_pre: got %0d want 2", rd_cnt); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd2) begin n_bad++; $display("FAIL simul_both: got %0d want 2", rd_cnt); end
        repeat (2) tick();
        mst_resp.r_valid = 1'b0;
        n_cmp++; if (rd_cnt !== 4'd0) begin n_bad++; $display("FAIL simul_drain: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_revert();
        bypass_req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL revert_drain: got %b want 1", busy); end
        bypass_req = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || bypass !== 1'b1) begin
            n_bad++; $display("FAIL revert_switch: got busy %b bypass %b want 1 1", busy, bypass);
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || bypass !== 1'b1) begin
            n_bad++; $display("FAIL revert_idle: got busy %b bypass %b want 0 1", busy, bypass);
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL revert_stays_idle: got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        mst_resp.aw_ready = 1'b1;
        slv_req.aw_valid = 1'b1;
        repeat (2) tick();
        slv_req.aw_valid = 1'b0;
        bypass_req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1 || wr_cnt !== 4'd2) begin
            n_bad++; $display("FAIL areset_pre: got busy %b cnt %0d want 1 2", busy, wr_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bypass !== 1'b0 || busy !== 1'b0 || wr_cnt !== 4'd0 || rd_cnt !== 4'd0) begin
            n_bad++; $display("FAIL areset_now: got bypass %b busy %b wr %0d rd %0d want 0 0 0 0", bypass, busy, wr_cnt, rd_cnt);
        end
        slv_req = '0;
        mst_resp = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_toggle();
        test_drain_writes();
        test_saturation();
        test_valid_stability();
        test_simul_incdec();
        test_revert();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chimera_wide_bypass_switch.md
Name: chimera_wide_bypass_switch

Overview:
- Sits directly upstream of the cluster AXI adapter's wide-path bypass-mode input, on the SoC-clock wide AXI path between the adapter's wide output and the SoC wide crossbar.
- Changes the wide memory bypass mode only while the wide path is quiescent, so no AXI transaction is split across a mode change.
- Tracks outstanding wide reads and writes, holds off new AW/AR while a switch is pending, and flips the mode once all outstanding transactions have drained.

Parameters:
- MaxTxn, 8: maximum outstanding transactions per direction (AW->B and AR->R-last); at the limit, new requests are held off.
- BypassDefault, 1'b0: bypass mode value applied at reset.
- axi_req_t, logic: wide AXI request struct type.
- axi_resp_t, logic: wide AXI response struct type.

Ports:
- soc_clk_i  in  1  clock.
- rst_i  in  1  reset.
- bypass_req_i  in  1  requested bypass mode (level).
- slv_req_i  in  axi_req_t  wide request from the cluster adapter.
- slv_resp_o  out  axi_resp_t  wide response to the cluster adapter.
- mst_req_o  out  axi_req_t  wide request to the SoC.
- mst_resp_i  in  axi_resp_t  wide response from the SoC.
- bypass_o  out  1  applied bypass mode, driven to the adapter's wide_mem_bypass_mode_i.
- busy_o  out  1  high while a mode switch is pending.
- wr_cnt_o  out  $clog2(MaxTxn+1)  outstanding write count.
- rd_cnt_o  out  $clog2(MaxTxn+1)  outstanding read count.

Behaviour:
- Clocking and reset: one clock, soc_clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: bypass_o=BypassDefault, busy_o=0, wr_cnt_o=0, rd_cnt_o=0, FSM=IDLE, aw_hold=0, ar_hold=0.
- Pass-through: W, B and R channels pass through combinationally with zero latency and are never gated. AW and AR payloads pass through unchanged.
- Gate condition for AW: gate_aw = (state!=IDLE) || (wr_cnt==MaxTxn).
- Gate condition for AR: gate_ar = (state!=IDLE) || (rd_cnt==MaxTxn).
- Gating action: while gated, mst aw_valid=0 and slv aw_ready=0 (AR likewise).
- AXI valid stability: aw_hold is set when mst aw_valid && !aw_ready, and cleared on handshake. While aw_hold=1 the AW channel is never gated, so a presented valid never drops. ar_hold works the same way for AR.
- Write counter: +1 on mst AW handshake, −1 on mst B handshake. If both occur in the same cycle, the count is unchanged.
- Read counter: +1 on mst AR handshake, −1 on mst R handshake with r.last. If both occur in the same cycle, the count is unchanged.
- Counter saturation:
  - Counters never exceed MaxTxn, because of gating.
  - A decrement at 0 is a protocol error: the counter holds at 0, and a simulation assertion fires.
- FSM transitions:
  - IDLE -> DRAIN when bypass_req_i != bypass_o.
  - DRAIN -> SWITCH when wr_cnt==0 && rd_cnt==0 && !aw_hold && !ar_hold, evaluated on registered values.
  - SWITCH -> IDLE after one cycle. On SWITCH entry, bypass_o <= bypass_req_i as sampled in the DRAIN exit cycle.
- busy_o is 1 in DRAIN and SWITCH.
- Mode change latency: when the path is idle and bypass_req_i toggles at cycle 0, the FSM is in DRAIN at cycle 1, SWITCH at cycle 2 (bypass_o flips), and IDLE at cycle 3. New AW/AR are accepted again from cycle 3.
- bypass_req_i reverting during DRAIN: the drain still completes. SWITCH writes the current request value; if that equals bypass_o, no change occurs.
- bypass_req_i changing while in SWITCH: the new value is picked up from IDLE on the next cycle.
- Reset mid-operation: counters, holds, FSM and bypass_o return to their reset values immediately. In-flight responses arriving after reset are not tracked (system-level reset is required to cover both sides).

Test Plan:
- Idle toggle: reset with BypassDefault=0, drive bypass_req_i=1 at cycle 5 -> busy_o=1 in cycles 6–7, bypass_o=1 at cycle 7, busy_o=0 at cycle 8, no AW/AR blocked beyond cycles 6–7.
- Drain with writes: issue 3 AWs (each 4 W beats), B responses delayed 20 cycles, toggle bypass_req_i after the third AW -> wr_cnt_o=3, a new AW is stalled (slv aw_ready=0), bypass_o flips exactly 2 cycles after the last B, and the stalled AW is accepted after that.
- Saturation: with MaxTxn=8, issue 9 ARs with R withheld -> rd_cnt_o=8 and AR 9 is stalled; one R with last=1 -> AR 9 is accepted the next cycle and rd_cnt_o stays 8.
- Valid stability: AW presented with mst aw_ready=0, then bypass_req_i toggled -> mst aw_valid stays 1 until the handshake, after which wr_cnt_o=1 and DRAIN waits for its B.
- Simultaneous inc/dec: an AR handshake and an R-last in the same cycle at rd_cnt_o=2 -> rd_cnt_o stays 2. Request reversion: bypass_req_i toggles and reverts during DRAIN -> bypass_o unchanged and busy_o drops after SWITCH.
- Async reset: assert rst_i mid-DRAIN with wr_cnt_o=2 -> all outputs take their reset values without a clock edge.
